lsu_mem_adapter: RTL and testbench
==================================

Name: lsu_mem_adapter

Overview:
- Load/store adapter directly downstream of the core's MEM-stage data port (data_addr/data_wdata/data_we/mem_size).
- Converts each core access into a word-aligned request on a req/gnt/rvalid memory bus: generates byte enables, lane-shifts store data, sign- or zero-extends load data.
- Detects misaligned, illegal-size and timed-out accesses.
- Holds the core stalled until the access completes.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ+WAIT before an access is aborted with an error.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- core_req_valid  input  1  core presents a load/store this cycle.
- core_we  input  1  1 = store, 0 = load.
- core_addr  input  32  byte address.
- core_wdata  input  32  store data, right-justified.
- core_size  input  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- core_rdata  output  32  extended load result; valid while core_done = 1.
- core_done  output  1  one-cycle completion pulse.
- core_err  output  1  one-cycle error pulse (misaligned, illegal size, timeout).
- core_stall  output  1  core must hold its pipeline.
- mem_req  output  1  request to memory.
- mem_addr  output  32  {addr[31:2], 2'b00}.
- mem_we  output  1  write enable.
- mem_be  output  4  byte enables.
- mem_wdata  output  32  lane-shifted store data.
- mem_gnt  input  1  memory accepted the request.
- mem_rvalid  input  1  response; returned for both loads and stores.
- mem_rdata  input  32  word read data.

Behaviour:
- Reset (rst = 1 at a clock edge):
  - state = IDLE; timeout counter = 0.
  - All outputs 0, including core_rdata and mem_*.
  - Reset during an outstanding access abandons it. No done or err pulse is generated; any later mem_rvalid is ignored in IDLE.
- FSM states: IDLE, REQ, WAIT, DONE, ERR.
- IDLE:
  - When core_req_valid = 1, classify the access:
    - Illegal size: core_size in {011, 110, 111}, or core_we = 1 with size 1xx.
    - Misaligned: halfword with addr[0] = 1, or word with addr[1:0] != 0.
  - Illegal or misaligned -> ERR. No memory access is issued.
  - Otherwise latch we/addr/wdata/size -> REQ.
- REQ:
  - mem_req = 1 with the latched fields, held stable until mem_gnt.
  - mem_gnt = 1 -> WAIT.
  - mem_rvalid seen in REQ is ignored.
- WAIT:
  - mem_req = 0.
  - mem_rvalid = 1 -> capture the extended mem_rdata (loads) -> DONE.
- DONE:
  - core_done = 1 for exactly one cycle.
  - core_rdata = extended value for loads, 0 for stores.
  - core_req_valid is ignored in this cycle -> IDLE.
- ERR:
  - core_err = 1 for one cycle; core_rdata = 0 -> IDLE.
- Timeout:
  - Counter clears on entry to REQ and increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES: drop mem_req -> ERR.
  - A response arriving in that same cycle is discarded (timeout wins).
- core_stall:
  - 1 in REQ and WAIT.
  - 1 in IDLE when core_req_valid = 1 and the access is legal.
  - 0 in DONE, ERR, and IDLE otherwise.
- Byte enables, with o = addr[1:0]:
  - B: 4'b0001 << o.
  - H: 4'b0011 << o.
  - W: 4'b1111.
  - Loads also drive mem_be with the same pattern.
- Store data:
  - B: {4{wdata[7:0]}}.
  - H: {2{wdata[15:0]}}.
  - W: wdata.
- Load extraction:
  - Select byte o or halfword o[1] of mem_rdata.
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- Latency (no memory wait):
  - Accept at cycle 0, gnt at cycle 1, rvalid at cycle 2, core_done at cycle 3.
  - The minimum is 4 cycles from accept to done, inclusive.
- Requests are strictly one outstanding; no pipelining.

Test Plan:
- Reset mid-WAIT, then mem_rvalid = 1 one cycle after reset releases -> state IDLE; no core_done or core_err; all outputs 0.
- LB addr 0x103, mem_rdata 0x80FF_1234, gnt and rvalid immediate -> mem_addr 0x100, mem_be 4'b1000, core_done at cycle 3, core_rdata 0xFFFF_FF80. Same access as LBU -> core_rdata 0x0000_0080.
- SH addr 0x202, wdata 0xDEAD_BEEF, gnt delayed 3 cycles -> mem_req held with mem_be 4'b1100, mem_wdata 0xBEEF_BEEF; core_stall high throughout; core_done pulse; core_rdata 0.
- LW addr 0x301 -> core_err pulse next cycle, mem_req never asserted, core_stall 0. Same with size 3'b011 -> same response.
- TIMEOUT_CYCLES = 4, gnt given but no rvalid -> core_err on the cycle after the count reaches 4; mem_req 0; state returns to IDLE.
- Back-to-back: LW 0x0 then SW 0x4 with core_req_valid held through DONE -> second access is accepted only in the following IDLE; exactly two core_done pulses.

Source files
------------

// File: rtl/lsu_mem_adapter.sv
// rtl/lsu_mem_adapter.sv - MEM-stage load/store to req/gnt/rvalid word bus adapter
module lsu_mem_adapter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req_valid,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [2:0]  core_size,
    output logic [31:0] core_rdata,
    output logic        core_done,
    output logic        core_err,
    output logic        core_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_ERR} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic              lat_we;
    logic [31:0]       lat_addr;
    logic [31:0]       lat_wdata;
    logic [2:0]        lat_size;
    logic [31:0]       rdata_q;

    logic              size_bad;
    logic              misaligned;
    logic              acc_ok;
    logic              timed_out;
    logic [1:0]        off;
    logic [3:0]        be;
    logic [31:0]       wdata_lane;
    logic [31:0]       shifted;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       ext;

    // Classify the incoming core access; only legal, aligned accesses reach memory
    always_comb begin
        size_bad   = (core_size[1:0] == 2'b11) || (core_size == 3'b110) ||
                     (core_we && core_size[2]);
        misaligned = ((core_size[1:0] == 2'b01) && core_addr[0]) ||
                     ((core_size[1:0] == 2'b10) && (core_addr[1:0] != 2'b00));
        acc_ok     = core_req_valid && !size_bad && !misaligned;
        timed_out  = (cnt == CNT_W'(TIMEOUT_CYCLES));
    end

    // Byte-lane steering for stores and sign/zero extension for loads
    always_comb begin
        off      = lat_addr[1:0];
        shifted  = mem_rdata >> {off, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = lat_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (lat_size[1:0])
            2'b00:   begin be = 4'b0001 << off; wdata_lane = {4{lat_wdata[7:0]}};  end
            2'b01:   begin be = 4'b0011 << off; wdata_lane = {2{lat_wdata[15:0]}}; end
            default: begin be = 4'b1111;        wdata_lane = lat_wdata;            end
        endcase
        case (lat_size)
            3'b000:  ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  ext = {24'h0, byte_sel};
            3'b001:  ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  ext = {16'h0, half_sel};
            default: ext = mem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Access latch, timeout counter and load result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_size  <= '0;
            rdata_q   <= '0;
        end else begin
            if (state == S_IDLE && acc_ok) begin
                cnt       <= '0;
                lat_we    <= core_we;
                lat_addr  <= core_addr;
                lat_wdata <= core_wdata;
                lat_size  <= core_size;
            end else if (state == S_REQ || state == S_WAIT) begin
                cnt <= cnt + 1'b1;
            end
            if (state == S_WAIT && mem_rvalid && !timed_out)
                rdata_q <= lat_we ? 32'h0 : ext;
        end
    end

    // Next-state logic; timeout takes priority over gnt/rvalid in the same cycle
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (core_req_valid) state_nx = acc_ok ? S_REQ : S_ERR;
            S_REQ:  if (timed_out) state_nx = S_ERR; else if (mem_gnt)    state_nx = S_WAIT;
            S_WAIT: if (timed_out) state_nx = S_ERR; else if (mem_rvalid) state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Output decode; memory fields are driven only while a request is live
    always_comb begin
        mem_req    = 1'b0;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_be     = '0;
        mem_wdata  = '0;
        if (state == S_REQ && !timed_out) begin
            mem_req   = 1'b1;
            mem_addr  = {lat_addr[31:2], 2'b00};
            mem_we    = lat_we;
            mem_be    = be;
            mem_wdata = wdata_lane;
        end
        core_done  = (state == S_DONE);
        core_err   = (state == S_ERR);
        core_rdata = (state == S_DONE) ? rdata_q : 32'h0;
        core_stall = (state == S_REQ) || (state == S_WAIT) || (state == S_IDLE && acc_ok);
    end

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// tb/tb_lsu_mem_adapter.sv - randomized self-checking bench for lsu_mem_adapter
module tb_lsu_mem_adapter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req_valid;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [2:0]  core_size;
    logic [31:0] core_rdata;
    logic        core_done;
    logic        core_err;
    logic        core_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lsu_mem_adapter #(.TIMEOUT_CYCLES(TO), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .core_req_valid(core_req_valid), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_size(core_size), .core_rdata(core_rdata),
        .core_done(core_done), .core_err(core_err), .core_stall(core_stall),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input bit we, input logic [2:0] sz, input logic [31:0] a);
        if (sz == 3 || sz == 6 || sz == 7) return 0;
        if (we && sz >= 4) return 0;
        if ((sz == 1 || sz == 5) && (a % 2 != 0)) return 0;
        if (sz == 2 && (a % 4 != 0)) return 0;
        return 1;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] sz, input logic [31:0] a);
        int w = sz % 4;
        if (w == 2) return 4'hF;
        return (w == 0 ? 4'd1 : 4'd3) << (a % 4);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] sz, input logic [31:0] d);
        int w = sz % 4;
        if (w == 0) return (d & 32'hFF) * 32'h0101_0101;
        if (w == 1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] sz, input logic [31:0] a,
                                             input logic [31:0] word);
        logic [31:0] v;
        int o = a % 4;
        int w = sz % 4;
        if (w == 2) return word;
        if (w == 0) begin
            v = (word >> (8 * o)) & 32'hFF;
            if (sz == 0 && v >= 128) v = v + 32'hFFFF_FF00;
        end else begin
            v = (word >> (16 * (o / 2))) & 32'hFFFF;
            if (sz == 1 && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic check_idle_zero(input string tag);
        check({tag, "_rdata"}, core_rdata, 0);
        check({tag, "_done"}, core_done, 0);
        check({tag, "_err"}, core_err, 0);
        check({tag, "_stall"}, core_stall, 0);
        check({tag, "_req"}, mem_req, 0);
        check({tag, "_maddr"}, mem_addr, 0);
        check({tag, "_mbe"}, mem_be, 0);
        check({tag, "_mwd"}, mem_wdata, 0);
        check({tag, "_mwe"}, mem_we, 0);
    endtask

    // One full access: dg = REQ cycles before gnt, dr = WAIT cycles before rvalid
    task automatic do_access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                             input logic [2:0] sz, input int dg, input int dr,
                             input logic [31:0] word);
        bit ok  = legal(we, sz, a);
        int fin = dg + 1 + dr;
        bit tmo = (dg >= TO) || (fin >= TO);
        int last = tmo ? TO : fin;
        bit in_req;
        @(negedge clk);
        core_req_valid = 1'b1; core_we = we; core_addr = a; core_wdata = wd; core_size = sz;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1;
        check("acc_stall", core_stall, ok);
        check("acc_req", mem_req, 0);
        @(negedge clk);
        core_req_valid = 1'b0;
        if (!ok) begin
            #1;
            check("bad_err", core_err, 1);
            check("bad_done", core_done, 0);
            check("bad_req", mem_req, 0);
            check("bad_stall", core_stall, 0);
            check("bad_rdata", core_rdata, 0);
        end else begin
            for (int k = 0; k <= last; k++) begin
                mem_gnt    = (k == dg);
                mem_rvalid = (k == fin) || (k <= dg && $urandom_range(0, 1) == 1);
                mem_rdata  = (k == fin) ? word : $urandom;
                #1;
                in_req = (k <= dg) && (k < TO);
                check("req", mem_req, in_req);
                check("stall", core_stall, 1);
                check("busy_done", core_done, 0);
                check("busy_err", core_err, 0);
                if (in_req) begin
                    check("maddr", mem_addr, a & 32'hFFFF_FFFC);
                    check("mbe", mem_be, exp_be(sz, a));
                    check("mwe", mem_we, we);
                    if (we) check("mwdata", mem_wdata, exp_wdata(sz, wd));
                end
                @(negedge clk);
            end
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            #1;
            if (tmo) begin
                check("tmo_err", core_err, 1);
                check("tmo_done", core_done, 0);
                check("tmo_rdata", core_rdata, 0);
            end else begin
                check("done", core_done, 1);
                check("done_err", core_err, 0);
                check("rdata", core_rdata, we ? 32'h0 : exp_load(sz, a, word));
            end
            check("end_stall", core_stall, 0);
            check("end_req", mem_req, 0);
        end
        @(negedge clk);
        #1;
        check("post_done", core_done, 0);
        check("post_err", core_err, 0);
    endtask

    initial begin
        int dones;
        logic [2:0]  sz;
        logic [31:0] a;
        bit          we;

        rst = 1'b1; core_req_valid = 1'b0; core_we = 1'b0; core_addr = '0;
        core_wdata = '0; core_size = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check_idle_zero("rst");
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        do_access(0, 32'h103, 32'h0, 3'b000, 0, 0, 32'h80FF_1234);
        do_access(0, 32'h103, 32'h0, 3'b100, 0, 0, 32'h80FF_1234);
        do_access(1, 32'h202, 32'hDEAD_BEEF, 3'b001, 2, 0, 32'h0);
        do_access(0, 32'h301, 32'h0, 3'b010, 0, 0, 32'h0);
        do_access(0, 32'h300, 32'h0, 3'b011, 0, 0, 32'h0);
        do_access(1, 32'h300, 32'h0, 3'b101, 0, 0, 32'h0);
        do_access(0, 32'h040, 32'h0, 3'b010, 0, 9, 32'h1234_5678);
        do_access(0, 32'h042, 32'h0, 3'b001, 1, 2, 32'h8765_4321);
        do_access(0, 32'h044, 32'h0, 3'b010, 4, 0, 32'h1);
        do_access(0, 32'h046, 32'h0, 3'b101, 0, 2, 32'hF00D_CAFE);

        // Reset while waiting for a response, then a stray rvalid
        @(negedge clk);
        core_req_valid = 1'b1; core_we = 1'b0; core_addr = 32'h10; core_size = 3'b010;
        @(negedge clk);
        core_req_valid = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        check("rw_stall", core_stall, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_5555;
        #1;
        check_idle_zero("rw0");
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        check_idle_zero("rw1");

        // Back-to-back with core_req_valid held through DONE
        dones = 0;
        @(negedge clk);
        core_req_valid = 1'b1; core_we = 1'b0; core_addr = 32'h0; core_size = 3'b010;
        core_wdata = 32'h0BAD_F00D; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin core_we = 1'b1; core_addr = 32'h4; end
            if (c == 8) core_req_valid = 1'b0;
            #1;
            if (core_done) dones++;
            if (c == 1) check("b2b_addr0", mem_addr, 32'h0);
            if (c == 3) check("b2b_rdata", core_rdata, 32'h1357_9BDF);
            if (c == 3) check("b2b_done_stall", core_stall, 0);
            if (c == 4) check("b2b_acc_stall", core_stall, 1);
            if (c == 4) check("b2b_acc_req", mem_req, 0);
            if (c == 5) check("b2b_addr1", mem_addr, 32'h4);
            if (c == 5) check("b2b_we", mem_we, 1);
            if (c == 7) check("b2b_done2", core_done, 1);
            @(negedge clk);
        end
        check("b2b_done_cnt", dones, 2);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;

        // Randomized accesses
        for (int i = 0; i < 80; i++) begin
            we = $urandom_range(0, 1);
            sz = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC | 32'($urandom_range(0, 1) * (sz % 4 == 0 ? 1 : 2));
            do_access(we, a, $urandom, sz, $urandom_range(0, 4), $urandom_range(0, 3), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
